fetch_unit_bp: RTL and testbench

- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline.
- Holds the PC register and the IF/ID pipeline register.
- Predicts conditional branches (beq) in IF using a 2-bit branch history table (BHT).
- Accepts branch resolution from ID/EX and redirects the PC and flushes IF/ID on mispredict. Replaces the fixed pc+4/jumpAdd mux plus the standalone PC and IF/ID blocks.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_bht.sv | 35 +++
 rtl/fetch_unit_bp.sv | 117 +++++++++++
 tb/tb_fetch_unit_bp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the predictable-branch opcode, the 2-bit branch counter type and its
// encodings, and the saturating counter update function.
package fetch_pkg;

    localparam logic [5:0] BRANCH_OP = 6'b000100;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT       = 2'b00;
    localparam ctr_t WNT       = 2'b01;
    localparam ctr_t WT        = 2'b10;
    localparam ctr_t ST        = 2'b11;
    localparam ctr_t CTR_RESET = WNT;

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: an array of 2-bit saturating counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_taken   combinational read: MSB of the indexed counter
//   upd_valid, upd_idx, upd_taken   counter update on the rising edge
// A read of an entry being updated in the same cycle returns the old value.
module fetch_bht
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_taken,
    input  logic                     upd_valid,
    input  logic [$clog2(DEPTH)-1:0] upd_idx,
    input  logic                     upd_taken
);

    ctr_t ctr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (upd_valid) begin
            ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/fetch_unit_bp.sv
// Instruction-fetch stage with PC register, IF/ID register and beq prediction.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_write, ifid_write     hazard stalls for PC and IF/ID (0 = hold)
//   imem_addr / imem_data    combinational instruction memory interface
//   ifid_*                   IF/ID register contents
//   res_*                    branch resolution from ID/EX
//   mispredict               resolved branch disagrees with its prediction
// Build option: FETCH_BHT_EN enables the 2-bit BHT and dynamic prediction;
// without it the stage predicts every branch not-taken.
module fetch_unit_bp
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     BHT_DEPTH     = 64,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter logic [5:0]      BRANCH_OPCODE = BRANCH_OP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            ifid_write,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic            ifid_pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            mispredict
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_target;
    logic            pred;

    logic [XLEN-1:0] ifid_instr_q, ifid_pc4_q;
    logic            ifid_valid_q, ifid_pred_q;

    assign imem_addr  = pc_q;
    assign pc_plus4   = pc_q + FOUR;
    assign mispredict = res_valid & (res_taken != res_pred_taken);

`ifdef FETCH_BHT_EN
    localparam int unsigned IW = $clog2(BHT_DEPTH);

    logic is_br;
    logic bht_taken;

    fetch_bht #(
        .DEPTH(BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_q[IW+1:2]),
        .rd_taken (bht_taken),
        .upd_valid(res_valid),
        .upd_idx  (res_pc[IW+1:2]),
        .upd_taken(res_taken)
    );

    assign is_br       = (imem_data[31:26] == BRANCH_OPCODE);
    assign pred        = is_br & bht_taken;
    assign pred_target = pc_plus4 + {{(XLEN-18){imem_data[15]}}, imem_data[15:0], 2'b00};
`else
    // Static not-taken: the target path is never selected.
    assign pred        = 1'b0;
    assign pred_target = pc_plus4;
`endif

    always_comb begin
        pc_d = pc_plus4;
        if (mispredict) begin
            pc_d = res_taken ? res_target : (res_pc + FOUR);
        end else if (!pc_write) begin
            pc_d = pc_q;
        end else if (pred) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A mispredict flushes the wrong-path instruction even during a stall.
    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pred_q  <= 1'b0;
        end else if (ifid_write) begin
            ifid_instr_q <= imem_data;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
            ifid_pred_q  <= pred;
        end
    end

    assign ifid_instr      = ifid_instr_q;
    assign ifid_pc4        = ifid_pc4_q;
    assign ifid_valid      = ifid_valid_q;
    assign ifid_pred_taken = ifid_pred_q;

endmodule

// File: tb/tb_fetch_unit_bp.sv
module tb_fetch_unit_bp;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        ifid_pred_taken;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        mispredict;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit_bp #(
        .XLEN     (32),
        .BHT_DEPTH(DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .ifid_pred_taken(ifid_pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_pred_taken (res_pred_taken),
        .res_target     (res_target),
        .mispredict     (mispredict)
    );

    always #5 clk = ~clk;

`ifdef FETCH_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    typedef struct {
        logic        rst, pw, iw;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
        logic        rt, rp;
        logic [31:0] rtg;
        logic [31:0] e_addr;
        logic        e_mp;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic r, logic pw, logic iw, logic [31:0] d, logic rv,
                                logic [31:0] rpc, logic rt, logic rp, logic [31:0] rtg,
                                logic [31:0] ea, logic em, logic ev, logic [31:0] ep,
                                logic [31:0] ei);
        vec_t v;
        v.rst = r; v.pw = pw; v.iw = iw; v.data = d; v.rv = rv; v.rpc = rpc;
        v.rt = rt; v.rp = rp; v.rtg = rtg; v.e_addr = ea; v.e_mp = em;
        v.e_valid = ev; v.e_pc4 = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are sampled 1 ns later.
    task automatic step_in(input logic r, input logic pw, input logic iw, input logic [31:0] d,
                           input logic rv, input logic [31:0] rpc, input logic rt,
                           input logic rp, input logic [31:0] rtg);
        @(negedge clk);
        rst = r; pc_write = pw; ifid_write = iw; imem_data = d;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_pred_taken = rp; res_target = rtg;
        #1;
    endtask

    function automatic logic [31:0] ins(int n);
        return 32'h0000_1000 + 32'(n);
    endfunction

    localparam logic [31:0] BEQ3 = 32'h1000_0003;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_pred;
    int          m_bht [DEPTH];

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_pred = 0;
        for (int i = 0; i < int'(DEPTH); i++) m_bht[i] = 1;
    endtask

    initial begin
        logic [31:0] d, rpc, rtg, tgt, off, nxt;
        logic        r, pw, iw, rv, rt, rp, is_br, pred, mp;
        logic [5:0]  opc;
        logic [15:0] imm;
        int          idx, ridx;

        tbl[0]  = mk(0, 1, 1, ins(0), 0, 0, 0, 0, 0,              0,     0, 0, 0,     0);
        tbl[1]  = mk(0, 1, 1, ins(1), 0, 0, 0, 0, 0,              4,     0, 1, 4,     ins(0));
        tbl[2]  = mk(0, 0, 0, ins(2), 0, 0, 0, 0, 0,              8,     0, 1, 8,     ins(1));
        tbl[3]  = mk(0, 0, 0, ins(2), 0, 0, 0, 0, 0,              8,     0, 1, 8,     ins(1));
        tbl[4]  = mk(0, 1, 1, ins(2), 0, 0, 0, 0, 0,              8,     0, 1, 8,     ins(1));
        tbl[5]  = mk(0, 0, 0, ins(3), 1, 32'h30, 1, 0, 32'h40,    12,    1, 1, 12,    ins(2));
        tbl[6]  = mk(0, 1, 1, ins(4), 0, 0, 0, 0, 0,              32'h40, 0, 0, 0,    0);
        tbl[7]  = mk(0, 1, 1, ins(5), 1, 32'h104, 0, 0, 0,        32'h44, 0, 1, 32'h44, ins(4));
        tbl[8]  = mk(0, 1, 0, ins(6), 1, 32'h208, 0, 1, 0,        32'h48, 1, 1, 32'h48, ins(5));
        tbl[9]  = mk(0, 1, 1, ins(7), 1, 32'h30C, 1, 1, 32'h999,  32'h20C, 0, 0, 0,   0);
        tbl[10] = mk(0, 1, 1, ins(8), 1, 32'hFFFF_FFFC, 0, 1, 0,  32'h210, 1, 1, 32'h210, ins(7));
        tbl[11] = mk(0, 1, 1, ins(9), 0, 0, 0, 0, 0,              0,     0, 0, 0,     0);
        tbl[12] = mk(1, 0, 0, ins(9), 1, 0, 1, 0, 32'h80,         4,     1, 1, 4,     ins(9));
        tbl[13] = mk(0, 1, 1, ins(10), 0, 0, 1, 0, 0,             0,     0, 0, 0,     0);

        // Two reset cycles
        @(negedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            step_in(tbl[i].rst, tbl[i].pw, tbl[i].iw, tbl[i].data, tbl[i].rv, tbl[i].rpc,
                    tbl[i].rt, tbl[i].rp, tbl[i].rtg);
            chk($sformatf("tbl%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.mispredict", i), 32'(mispredict), 32'(tbl[i].e_mp));
            chk($sformatf("tbl%0d.ifid_valid", i), 32'(ifid_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.ifid_pc4", i), ifid_pc4, tbl[i].e_pc4);
            chk($sformatf("tbl%0d.ifid_instr", i), ifid_instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d.ifid_pred", i), 32'(ifid_pred_taken), 32'h0);
        end

        // Training and correction sequence
        step_in(1, 1, 1, NOP, 0, 0, 0, 0, 0);
        step_in(1, 1, 1, NOP, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step_in(0, 0, 0, NOP, 1, 32'h10, 1, 1, 32'h50);
            chk("train.imem_addr", imem_addr, 32'h0);
            chk("train.mispredict", 32'(mispredict), 32'h0);
        end
        step_in(0, 1, 1, NOP, 1, 32'h8, 1, 0, 32'h10);
        chk("redir1.mispredict", 32'(mispredict), 32'h1);
        step_in(0, 1, 1, BEQ3, 0, 0, 0, 0, 0);
        chk("beq1.imem_addr", imem_addr, 32'h10);
        chk("beq1.ifid_valid", 32'(ifid_valid), 32'h0);
        step_in(0, 1, 1, NOP, 1, 32'h10, 0, 1, 0);
        chk("beq1.next_addr", imem_addr, BHT_ON ? 32'h20 : 32'h14);
        chk("beq1.ifid_pred", 32'(ifid_pred_taken), 32'(BHT_ON));
        chk("beq1.ifid_pc4", ifid_pc4, 32'h14);
        chk("beq1.ifid_instr", ifid_instr, BEQ3);
        chk("ntcorr.mispredict", 32'(mispredict), 32'h1);
        step_in(0, 1, 1, NOP, 1, 32'h40, 1, 0, 32'h10);
        chk("ntcorr.imem_addr", imem_addr, 32'h14);
        chk("ntcorr.ifid_valid", 32'(ifid_valid), 32'h0);
        step_in(0, 1, 1, BEQ3, 0, 0, 0, 0, 0);
        chk("beq2.imem_addr", imem_addr, 32'h10);
        // Counter saturated at 11, so one not-taken leaves it predicting taken
        step_in(0, 1, 1, NOP, 1, 32'h10, 0, 1, 0);
        chk("beq2.next_addr", imem_addr, BHT_ON ? 32'h20 : 32'h14);
        chk("beq2.ifid_pred", 32'(ifid_pred_taken), 32'(BHT_ON));
        step_in(0, 1, 1, NOP, 1, 32'h44, 1, 0, 32'h10);
        chk("ntcorr2.imem_addr", imem_addr, 32'h14);
        // Same-cycle update of the read entry: prediction sees the old counter (01)
        step_in(0, 1, 1, BEQ3, 1, 32'h10, 1, 1, 32'h50);
        chk("beq3.imem_addr", imem_addr, 32'h10);
        chk("beq3.mispredict", 32'(mispredict), 32'h0);
        step_in(0, 1, 1, NOP, 0, 0, 0, 0, 0);
        chk("beq3.next_addr", imem_addr, 32'h14);
        chk("beq3.ifid_pred", 32'(ifid_pred_taken), 32'h0);
        chk("beq3.ifid_valid", 32'(ifid_valid), 32'h1);

        // Randomized phase against the reference model
        step_in(1, 1, 1, NOP, 0, 0, 0, 0, 0);
        step_in(1, 1, 1, NOP, 0, 0, 0, 0, 0);
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            pw = ($urandom_range(0, 6) != 0);
            iw = ($urandom_range(0, 6) != 0);
            if ($urandom_range(0, 2) == 0) begin
                imm = 16'($urandom_range(0, 32)) - 16'd16;
                d   = {6'b000100, 10'($urandom), imm};
            end else begin
                opc = 6'($urandom);
                if (opc == 6'b000100) opc = 6'b0;
                d = {opc, 26'($urandom)};
            end
            rv  = ($urandom_range(0, 2) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? m_pc : (32'($urandom_range(0, 127)) * 4);
            rt  = 1'($urandom);
            rp  = 1'($urandom);
            rtg = 32'($urandom_range(0, 127)) * 4;

            step_in(r, pw, iw, d, rv, rpc, rt, rp, rtg);
            mp = rv && (rt != rp);
            chk("rnd.imem_addr", imem_addr, m_pc);
            chk("rnd.mispredict", 32'(mispredict), 32'(mp));
            chk("rnd.ifid_instr", ifid_instr, m_instr);
            chk("rnd.ifid_pc4", ifid_pc4, m_pc4);
            chk("rnd.ifid_valid", 32'(ifid_valid), 32'(m_valid));
            chk("rnd.ifid_pred", 32'(ifid_pred_taken), 32'(m_pred));

            idx   = int'((m_pc / 4) % DEPTH);
            is_br = (d[31:26] == 6'd4);
            pred  = BHT_ON && is_br && (m_bht[idx] >= 2);
            off   = 32'($signed(d[15:0])) * 4;
            tgt   = m_pc + 4 + off;
            if (r) begin
                model_reset();
            end else begin
                if (mp)        nxt = rt ? rtg : rpc + 4;
                else if (!pw)  nxt = m_pc;
                else if (pred) nxt = tgt;
                else           nxt = m_pc + 4;
                if (mp) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0; m_pred = 0;
                end else if (iw) begin
                    m_instr = d; m_pc4 = m_pc + 4; m_valid = 1; m_pred = pred;
                end
                if (rv) begin
                    ridx = int'((rpc / 4) % DEPTH);
                    if (rt) m_bht[ridx] = (m_bht[ridx] == 3) ? 3 : m_bht[ridx] + 1;
                    else    m_bht[ridx] = (m_bht[ridx] == 0) ? 0 : m_bht[ridx] - 1;
                end
                m_pc = nxt;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
